// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA timing generator / pixel-stream formatter.
// Default timing is 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        SEEK       = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam logic [1:0] MODE_MONO = 2'd0;
    localparam logic [1:0] MODE_GREY = 2'd1;
    localparam logic [1:0] MODE_RGB  = 2'd2;
    localparam logic [1:0] MODE_BARS = 2'd3;

    localparam int CNT_W = 11;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Colour-bar table, left to right across the active line.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Free-running H/V raster counters with raw (active-high) sync and active-area decode.
module vga_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             frame_end
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic h_last, v_last;

    assign h_last    = (hcnt == CNT_W'(H_TOTAL - 1));
    assign v_last    = (vcnt == CNT_W'(V_TOTAL - 1));
    assign frame_end = h_last && v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    assign active    = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    assign hsync_raw = (hcnt >= CNT_W'(H_ACTIVE + H_FP)) && (hcnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_raw = (vcnt >= CNT_W'(V_ACTIVE + V_FP)) && (vcnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_stream_timingen.sv
// VGA timing generator that pops a frame-tagged FWFT pixel stream and formats it
// for the DAC; outputs are registered one clock behind the raster counters.
module vga_stream_timingen
    import vga_timing_pkg::*;
#(
    parameter int          H_ACTIVE  = DEF_H_ACTIVE,
    parameter int          H_FP      = DEF_H_FP,
    parameter int          H_SYNC    = DEF_H_SYNC,
    parameter int          H_BP      = DEF_H_BP,
    parameter int          V_ACTIVE  = DEF_V_ACTIVE,
    parameter int          V_FP      = DEF_V_FP,
    parameter int          V_SYNC    = DEF_V_SYNC,
    parameter int          V_BP      = DEF_V_BP,
    parameter logic        SYNC_ACT  = 1'b0,
    parameter logic [23:0] UNDER_RGB = 24'h7F0000
) (
    input  logic        clk_25mhz,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_data,
    input  logic        fifo_sof,
    output logic        fifo_read,
    output logic        hsync,
    output logic        vsync,
    output logic        comp_sync,
    output logic        blank,
    output logic [7:0]  pixel_r,
    output logic [7:0]  pixel_g,
    output logic [7:0]  pixel_b,
    output logic        resyncing,
    output logic        frame_start,
    output logic [15:0] underflow_cnt
);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             active, hsync_raw, vsync_raw, frame_end, origin;
    logic             pop, under, h_lvl, v_lvl;
    logic [23:0]      fmt_rgb, pix_nxt;
    logic [2:0]       bar_idx;

    vga_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_counter (
        .clk(clk_25mhz), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .active(active),
        .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .frame_end(frame_end)
    );

    assign origin  = (hcnt == '0) && (vcnt == '0);
    assign bar_idx = 3'(hcnt / CNT_W'(BAR_W));

    always_comb begin
        case (mode)
            MODE_MONO: fmt_rgb = {24{fifo_data[0]}};
            MODE_GREY: fmt_rgb = {3{fifo_data[7:0]}};
            default:   fmt_rgb = fifo_data;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        under     = 1'b0;
        pix_nxt   = '0;
        if (!enable) begin
            state_nxt = SEEK;
        end else if (mode == MODE_BARS) begin
            if (active) pix_nxt = bar_rgb(bar_idx);
        end else begin
            case (state)
                SEEK: begin
                    pop = !fifo_empty && !fifo_sof;
                    if (!fifo_empty && fifo_sof) state_nxt = WAIT_FRAME;
                end
                // WAIT_FRAME joins the RUN pixel path exactly at (0,0)
                WAIT_FRAME, RUN: begin
                    if (active && (state == RUN || origin)) begin
                        state_nxt = RUN;
                        if (fifo_empty) begin
                            under   = 1'b1;
                            pix_nxt = UNDER_RGB;
                        end else if (fifo_sof && !origin) begin
                            state_nxt = WAIT_FRAME;
                        end else if (!fifo_sof && origin) begin
                            state_nxt = SEEK;
                        end else begin
                            pop     = 1'b1;
                            pix_nxt = fmt_rgb;
                        end
                    end
                end
                default: state_nxt = SEEK;
            endcase
        end
    end

    assign fifo_read = pop && !rst;
    assign resyncing = (state != RUN);
    assign h_lvl     = hsync_raw ? SYNC_ACT : ~SYNC_ACT;
    assign v_lvl     = vsync_raw ? SYNC_ACT : ~SYNC_ACT;

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state         <= SEEK;
            hsync         <= ~SYNC_ACT;
            vsync         <= ~SYNC_ACT;
            comp_sync     <= ~SYNC_ACT;
            blank         <= 1'b1;
            pixel_r       <= '0;
            pixel_g       <= '0;
            pixel_b       <= '0;
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            state     <= state_nxt;
            hsync     <= h_lvl;
            vsync     <= v_lvl;
            comp_sync <= (SYNC_ACT == 1'b0) ? ~(h_lvl ^ v_lvl) : (h_lvl & v_lvl);
            blank     <= !active;
            {pixel_r, pixel_g, pixel_b} <= pix_nxt;
            frame_start <= frame_end;
            if (under && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule
